// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencing controller.
// A Moore FSM walks each instruction through fetch, decode, execute, memory
// and writeback. It drives the mux selects and write enables of a datapath
// that shares one ALU and one unified memory. Memory states stretch by
// MEM_WAIT cycles, and the controller freezes while stall is high.
module multicycle_control #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       halt,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRAN  = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // The wait counter is always at least one bit wide, even for single-cycle memory.
  localparam int CNT_W = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT);

  state_t           cur_state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             last_wait;
  logic             mem_state;
  logic             pc_we, ir_we, mem_we, rf_we;

  // These are the only funct3 values the shared ALU supports for R/I ops.
  function automatic logic alu_funct3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Map funct3/funct7b5 to an ALU operation. Subtract is only legal for R-type (op[5]=1).
  function automatic logic [2:0] alu_decode(input logic op5, input logic [2:0] f3,
                                            input logic f7b5);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  ctl = ALU_SLT;
      3'b110:  ctl = ALU_OR;
      3'b111:  ctl = ALU_AND;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  assign last_wait = (wait_cnt == CNT_LAST);
  assign mem_state = (cur_state == S_FETCH) || (cur_state == S_MEMREAD) ||
                     (cur_state == S_MEMWRITE);

  // State register and memory wait counter; the counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
    end else begin
      cur_state <= next_state;
      if (next_state != cur_state)
        wait_cnt <= '0;
      else if (!stall && mem_state && !last_wait)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Next-state logic; stall holds the current state.
  always_comb begin
    next_state = cur_state;
    if (!stall) begin
      case (cur_state)
        S_FETCH:    if (last_wait) next_state = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: next_state = S_MEMADR;
            OP_RTYPE:          next_state = alu_funct3_ok(funct3) ? S_EXECR : S_ERROR;
            OP_ITYPE:          next_state = alu_funct3_ok(funct3) ? S_EXECI : S_ERROR;
            OP_BRAN:           next_state = S_BEQ;
            OP_JAL:            next_state = S_JAL;
            default:           next_state = S_ERROR;
          endcase
        end
        S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (last_wait) next_state = S_MEMWB;
        S_MEMWB:    next_state = S_FETCH;
        S_MEMWRITE: if (last_wait) next_state = S_FETCH;
        S_EXECR:    next_state = S_ALUWB;
        S_EXECI:    next_state = S_ALUWB;
        S_ALUWB:    next_state = S_FETCH;
        S_BEQ:      next_state = S_FETCH;
        S_JAL:      next_state = S_ALUWB;
        S_ERROR:    next_state = S_ERROR;
        default:    next_state = S_ERROR;
      endcase
    end
  end

  // Moore outputs per state: selects plus raw (ungated) write enables.
  always_comb begin
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REG;
    ALUControl = ALU_ADD;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    case (cur_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        pc_we     = last_wait;
        ir_we     = last_wait;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        rf_we     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = last_wait;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_REG;
        ALUControl = alu_decode(op[5], funct3, funct7b5);
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_decode(op[5], funct3, funct7b5);
      end
      S_ALUWB:    rf_we = 1'b1;
      S_BEQ: begin
        ALUSrcA    = SRCA_REG;
        ALUControl = ALU_SUB;
        pc_we      = zero;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pc_we   = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format is a pure function of the opcode.
  always_comb begin
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BRAN:  ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  // Reset or stall suppresses every architectural write; selects are left untouched.
  always_comb begin
    PCWrite  = pc_we  & reset & ~stall;
    IRWrite  = ir_we  & reset & ~stall;
    MemWrite = mem_we & reset & ~stall;
    RegWrite = rf_we  & reset & ~stall;
  end

  assign halt  = (cur_state == S_ERROR);
  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: table of per-cycle vectors on a
// MEM_WAIT=0 instance plus hand sequences on MEM_WAIT=2 and the ERROR path.
module tb_multicycle_control;

  localparam int LW  = 'b0000011;
  localparam int SW  = 'b0100011;
  localparam int RT  = 'b0110011;
  localparam int IT  = 'b0010011;
  localparam int BR  = 'b1100011;
  localparam int JL  = 'b1101111;
  localparam int BAD = 'b1111111;

  logic       clk = 1'b0;
  logic       reset, stall, funct7b5, zero;
  logic [6:0] op;
  logic [2:0] funct3;

  logic       pcw0, adr0, mw0, irw0, rw0, halt0;
  logic [1:0] res0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic [3:0] st0;
  logic       pcw2, adr2, mw2, irw2, rw2, halt2;
  logic [1:0] res2, sa2, sb2, imm2;
  logic [2:0] alu2;
  logic [3:0] st2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT(0)) u0 (
    .clk(clk), .reset(reset), .stall(stall), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .PCWrite(pcw0), .AdrSrc(adr0),
    .MemWrite(mw0), .IRWrite(irw0), .ResultSrc(res0), .ALUSrcA(sa0),
    .ALUSrcB(sb0), .ALUControl(alu0), .ImmSrc(imm0), .RegWrite(rw0),
    .halt(halt0), .state(st0));

  multicycle_control #(.MEM_WAIT(2)) u2 (
    .clk(clk), .reset(reset), .stall(stall), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .PCWrite(pcw2), .AdrSrc(adr2),
    .MemWrite(mw2), .IRWrite(irw2), .ResultSrc(res2), .ALUSrcA(sa2),
    .ALUSrcB(sb2), .ALUControl(alu2), .ImmSrc(imm2), .RegWrite(rw2),
    .halt(halt2), .state(st2));

  logic [20:0] act0, act2;
  assign act0 = {st0, pcw0, irw0, mw0, rw0, adr0, res0, sa0, sb0, alu0, imm0, halt0};
  assign act2 = {st2, pcw2, irw2, mw2, rw2, adr2, res2, sa2, sb2, alu2, imm2, halt2};

  typedef struct {
    logic       rst_n, stl;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z;
    logic [3:0] st, en;
    logic       adr;
    logic [1:0] res, sa, sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       halt;
  } vec_t;

  vec_t vecs[$];

  // en is {PCWrite, IRWrite, MemWrite, RegWrite}
  task automatic v(input int rst_n, input int stl, input int o, input int f3, input int f7,
                   input int z, input int st, input int en, input int adr, input int res,
                   input int sa, input int sb, input int alu, input int imm, input int hlt);
    vec_t r;
    r.rst_n = 1'(rst_n); r.stl = 1'(stl); r.op = 7'(o); r.f3 = 3'(f3);
    r.f7 = 1'(f7); r.z = 1'(z); r.st = 4'(st); r.en = 4'(en); r.adr = 1'(adr);
    r.res = 2'(res); r.sa = 2'(sa); r.sb = 2'(sb); r.alu = 3'(alu);
    r.imm = 2'(imm); r.halt = 1'(hlt);
    vecs.push_back(r);
  endtask

  task automatic drive(input logic r, input logic s, input int o, input logic z);
    @(negedge clk);
    reset = r; stall = s; op = 7'(o); zero = z;
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  initial begin
    logic [20:0] exp_v;
    reset = 1'b0; stall = 1'b0; op = 7'(LW); funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;

    // reset held, enables forced low
    v(0,0,LW,0,0,0,  0,'b0000,0,'b10,'b00,'b10,'b000,'b00,0);
    v(0,0,LW,0,0,0,  0,'b0000,0,'b10,'b00,'b10,'b000,'b00,0);
    // lw: 0,1,2,3,4
    v(1,0,LW,0,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b00,0);
    v(1,0,LW,0,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);
    v(1,0,LW,0,0,0,  2,'b0000,0,'b00,'b10,'b01,'b000,'b00,0);
    v(1,0,LW,0,0,0,  3,'b0000,1,'b00,'b00,'b00,'b000,'b00,0);
    v(1,0,LW,0,0,0,  4,'b0001,0,'b01,'b00,'b00,'b000,'b00,0);
    // R-type sub
    v(1,0,RT,0,1,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b00,0);
    v(1,0,RT,0,1,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);
    v(1,0,RT,0,1,0,  6,'b0000,0,'b00,'b10,'b00,'b001,'b00,0);
    v(1,0,RT,0,1,0,  8,'b0001,0,'b00,'b00,'b00,'b000,'b00,0);
    // addi with IR[30] set is still add
    v(1,0,IT,0,1,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b00,0);
    v(1,0,IT,0,1,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);
    v(1,0,IT,0,1,0,  7,'b0000,0,'b00,'b10,'b01,'b000,'b00,0);
    v(1,0,IT,0,1,0,  8,'b0001,0,'b00,'b00,'b00,'b000,'b00,0);
    // beq taken
    v(1,0,BR,0,0,1,  0,'b1100,0,'b10,'b00,'b10,'b000,'b10,0);
    v(1,0,BR,0,0,1,  1,'b0000,0,'b00,'b01,'b01,'b000,'b10,0);
    v(1,0,BR,0,0,1,  9,'b1000,0,'b00,'b10,'b00,'b001,'b10,0);
    // beq not taken
    v(1,0,BR,0,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b10,0);
    v(1,0,BR,0,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b10,0);
    v(1,0,BR,0,0,0,  9,'b0000,0,'b00,'b10,'b00,'b001,'b10,0);
    // jal
    v(1,0,JL,0,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b11,0);
    v(1,0,JL,0,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b11,0);
    v(1,0,JL,0,0,0, 10,'b1000,0,'b00,'b01,'b10,'b000,'b11,0);
    v(1,0,JL,0,0,0,  8,'b0001,0,'b00,'b00,'b00,'b000,'b11,0);
    // sw
    v(1,0,SW,0,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b01,0);
    v(1,0,SW,0,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b01,0);
    v(1,0,SW,0,0,0,  2,'b0000,0,'b00,'b10,'b01,'b000,'b01,0);
    v(1,0,SW,0,0,0,  5,'b0010,1,'b00,'b00,'b00,'b000,'b01,0);
    // slt
    v(1,0,RT,2,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b00,0);
    v(1,0,RT,2,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);
    v(1,0,RT,2,0,0,  6,'b0000,0,'b00,'b10,'b00,'b101,'b00,0);
    v(1,0,RT,2,0,0,  8,'b0001,0,'b00,'b00,'b00,'b000,'b00,0);
    // andi
    v(1,0,IT,7,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b00,0);
    v(1,0,IT,7,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);
    v(1,0,IT,7,0,0,  7,'b0000,0,'b00,'b10,'b01,'b010,'b00,0);
    v(1,0,IT,7,0,0,  8,'b0001,0,'b00,'b00,'b00,'b000,'b00,0);
    // or
    v(1,0,RT,6,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b00,0);
    v(1,0,RT,6,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);
    v(1,0,RT,6,0,0,  6,'b0000,0,'b00,'b10,'b00,'b011,'b00,0);
    v(1,0,RT,6,0,0,  8,'b0001,0,'b00,'b00,'b00,'b000,'b00,0);
    // unsupported funct3 -> ERROR, then reset out of it
    v(1,0,RT,1,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b00,0);
    v(1,0,RT,1,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);
    v(1,0,RT,1,0,0, 15,'b0000,0,'b00,'b00,'b00,'b000,'b00,1);
    v(1,0,RT,1,0,0, 15,'b0000,0,'b00,'b00,'b00,'b000,'b00,1);
    v(0,0,RT,1,0,0, 15,'b0000,0,'b00,'b00,'b00,'b000,'b00,1);
    v(1,0,LW,0,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b00,0);
    // stall in DECODE, then reset beats stall in MEMWB
    v(1,1,LW,0,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);
    v(1,0,LW,0,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);
    v(1,0,LW,0,0,0,  2,'b0000,0,'b00,'b10,'b01,'b000,'b00,0);
    v(1,0,LW,0,0,0,  3,'b0000,1,'b00,'b00,'b00,'b000,'b00,0);
    v(0,1,LW,0,0,0,  4,'b0000,0,'b01,'b00,'b00,'b000,'b00,0);
    v(1,0,LW,0,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b00,0);
    // reset aborts DECODE; stalled FETCH has no enables
    v(0,0,LW,0,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);
    v(1,1,LW,0,0,0,  0,'b0000,0,'b10,'b00,'b10,'b000,'b00,0);
    v(1,0,LW,0,0,0,  0,'b1100,0,'b10,'b00,'b10,'b000,'b00,0);
    v(1,0,LW,0,0,0,  1,'b0000,0,'b00,'b01,'b01,'b000,'b00,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst_n; stall = vecs[i].stl; op = vecs[i].op;
      funct3 = vecs[i].f3; funct7b5 = vecs[i].f7; zero = vecs[i].z;
      #1;
      exp_v = {vecs[i].st, vecs[i].en, vecs[i].adr, vecs[i].res, vecs[i].sa,
               vecs[i].sb, vecs[i].alu, vecs[i].imm, vecs[i].halt};
      tests++;
      if (act0 !== exp_v) begin
        fails++;
        $display("FAIL vec%0d: got %h want %h", i, act0, exp_v);
      end
    end

    // MEM_WAIT=2 store with stalls inside MEMWRITE; result is {state, en}
    funct3 = 3'b000; funct7b5 = 1'b0;
    drive(0, 0, SW, 0);
    drive(0, 0, SW, 0);
    chk("w2_rst", int'(act2[20:13]), 'h00);
    drive(1, 0, SW, 0); chk("w2_fetch0", int'(act2[20:13]), 'h00);
    drive(1, 0, SW, 0); chk("w2_fetch1", int'(act2[20:13]), 'h00);
    drive(1, 0, SW, 0); chk("w2_fetch2", int'(act2[20:13]), 'h0C);
    drive(1, 0, SW, 0); chk("w2_decode", int'(act2[20:13]), 'h10);
    drive(1, 0, SW, 0); chk("w2_memadr", int'(act2[20:13]), 'h20);
    drive(1, 0, SW, 0); chk("w2_mw0", int'(act2[20:13]), 'h50);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, SW, 0); chk("w2_mw_stall", int'(act2[20:13]), 'h50);
    end
    chk("w2_stall_adr", int'(adr2), 1);
    drive(1, 0, SW, 0); chk("w2_mw1", int'(act2[20:13]), 'h50);
    drive(1, 1, SW, 0); chk("w2_mw2_stall", int'(act2[20:13]), 'h50);
    drive(1, 0, SW, 0);
    chk("w2_mw2_full", int'(act2), int'({4'd5, 4'b0010, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0}));
    drive(1, 0, SW, 0); chk("w2_fetch_next0", int'(act2[20:13]), 'h00);
    drive(1, 0, SW, 0); chk("w2_fetch_next1", int'(act2[20:13]), 'h00);
    drive(1, 1, SW, 0); chk("w2_fetch_stall", int'(act2[20:13]), 'h00);
    drive(1, 0, SW, 0); chk("w2_fetch_last", int'(act2[20:13]), 'h0C);
    drive(1, 0, SW, 0); chk("w2_decode2", int'(act2[20:13]), 'h10);

    // illegal opcode: ERROR sticks with halt until a one-cycle reset
    drive(0, 0, BAD, 0);
    drive(1, 0, BAD, 0); chk("err_fetch", int'({act0[20:13], act0[0]}), 'h018);
    drive(1, 0, BAD, 0); chk("err_decode", int'({act0[20:13], act0[0]}), 'h020);
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, BAD, 0); chk("err_hold", int'({act0[20:13], act0[0]}), 'h1E1);
    end
    drive(0, 0, LW, 0); chk("err_in_rst", int'({act0[20:13], act0[0]}), 'h1E1);
    drive(1, 0, LW, 0); chk("err_released", int'({act0[20:13], act0[0]}), 'h018);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
